ss_sequencer: RTL and testbench

- Sequences the mapper save-state register port.
- Save: walks register addresses 0..REG_CNT-1 and then IDX_ADDR, reading each byte and emitting it on an output byte stream.
- Restore: accepts a byte stream, writes each byte into the mapper register file, with every write timed to straddle a falling edge of m2. It then checks the mapper index byte.
- Sits between the host save-state DMA and the mapper's ss_act/ss_we/ss_addr/ss_rdat bus.

---
 rtl/ss_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ss_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_sequencer.sv
// Save-state sequencer for the mapper register port.
// Save walks registers 0..REG_CNT-1 plus the index byte out onto a byte stream.
// Restore writes a byte stream back, with each write straddling an m2 fall,
// and then checks the mapper index byte.
module ss_sequencer #(
  parameter int REG_CNT     = 12,
  parameter int IDX_ADDR    = 127,
  parameter int SETTLE      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TMO         = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       m2,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] sv_dat,
  output logic       sv_valid,
  input  logic       sv_ready,
  input  logic [7:0] ld_dat,
  input  logic       ld_valid,
  output logic       ld_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_SV_ADDR, S_SV_OUT, S_LD_DAT, S_LD_HI,
    S_LD_FALL, S_LD_HOLD, S_LD_SET, S_DONE
  } state_t;

  // One counter serves both the address-settle window and the m2 timeout.
  localparam int            CW       = $clog2((TMO > SETTLE) ? TMO : SETTLE) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [7:0]    REG_END  = 8'(REG_CNT);
  localparam logic [7:0]    IDX_A    = 8'(IDX_ADDR);

  state_t          state, state_n;
  logic [7:0]      idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      addr_n, wdat_n, svdat_n;
  logic            err_n;

  logic [SYNC_STAGES-1:0] m2_sync;
  logic                   m2s, m2s_q, fall;

  assign m2s  = m2_sync[SYNC_STAGES-1];
  assign fall = m2s_q & ~m2s;

  // Register addresses map straight through; past the last one comes the index byte.
  function automatic logic [7:0] sel_addr(input logic [7:0] i);
    return (i < REG_END) ? i : IDX_A;
  endfunction

  // Synchronize the asynchronous m2 and keep one stage of history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync <= '0;
      m2s_q   <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[SYNC_STAGES-2:0], m2};
      m2s_q   <= m2s;
    end
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      ss_addr <= '0;
      ss_wdat <= '0;
      sv_dat  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      ss_addr <= addr_n;
      ss_wdat <= wdat_n;
      sv_dat  <= svdat_n;
      err     <= err_n;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    addr_n  = ss_addr;
    wdat_n  = ss_wdat;
    svdat_n = sv_dat;
    err_n   = err;

    if (abort && ss_act) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            err_n = 1'b0;
            idx_n = '0;
            cnt_n = '0;
            if (dir) begin
              state_n = S_LD_DAT;
            end else begin
              addr_n  = sel_addr(8'd0);
              state_n = S_SV_ADDR;
            end
          end
        end
        S_SV_ADDR: begin
          if (cnt == SET_LAST) begin
            svdat_n = ss_rdat;
            state_n = S_SV_OUT;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_SV_OUT: begin
          if (sv_ready) begin
            if (ss_addr == IDX_A) begin
              state_n = S_DONE;
            end else begin
              idx_n   = idx + 8'd1;
              addr_n  = sel_addr(idx + 8'd1);
              cnt_n   = '0;
              state_n = S_SV_ADDR;
            end
          end
        end
        S_LD_DAT: begin
          if (ld_valid) begin
            if (idx < REG_END) begin
              wdat_n  = ld_dat;
              addr_n  = idx;
              cnt_n   = '0;
              state_n = S_LD_HI;
            end else begin
              // ss_addr already points at the index byte and has settled.
              if (ld_dat != ss_rdat) err_n = 1'b1;
              state_n = S_DONE;
            end
          end
        end
        S_LD_HI: begin
          if (m2s) begin
            cnt_n   = '0;
            state_n = S_LD_FALL;
          end else if (cnt == TMO_LAST) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_LD_FALL: begin
          if (fall) begin
            state_n = S_LD_HOLD;
          end else if (cnt == TMO_LAST) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_LD_HOLD: begin
          // Write strobe stays up one cycle past the fall, then the index advances.
          idx_n = idx + 8'd1;
          if (idx + 8'd1 == REG_END) begin
            addr_n  = IDX_A;
            cnt_n   = '0;
            state_n = S_LD_SET;
          end else begin
            state_n = S_LD_DAT;
          end
        end
        S_LD_SET: begin
          if (cnt == SET_LAST) state_n = S_LD_DAT;
          else                 cnt_n   = cnt + CW'(1);
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Control outputs are pure decodes of the registered state.
  assign ss_act   = (state != S_IDLE) && (state != S_DONE);
  assign busy     = ss_act;
  assign done     = (state == S_DONE);
  assign ss_we    = (state == S_LD_HI) || (state == S_LD_FALL) || (state == S_LD_HOLD);
  assign sv_valid = (state == S_SV_OUT);
  assign ld_ready = (state == S_LD_DAT);

endmodule

// File: tb/tb_ss_sequencer.sv
// Directed bench for ss_sequencer with a behavioural mapper register file.
module tb_ss_sequencer;
  localparam int REG_CNT  = 12;
  localparam int IDX_ADDR = 127;
  localparam int TMO      = 1024;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic       m2 = 1'b0, sv_ready = 1'b1, ld_valid = 1'b0;
  logic [7:0] ld_dat = 8'h00;
  logic       busy, done, err, ss_act, ss_we, sv_valid, ld_ready;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, sv_dat;

  int tests = 0, fails = 0;

  ss_sequencer #(.REG_CNT(REG_CNT), .IDX_ADDR(IDX_ADDR), .SETTLE(2),
                 .SYNC_STAGES(2), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
    .busy(busy), .done(done), .err(err), .m2(m2), .ss_act(ss_act),
    .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .sv_dat(sv_dat), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .ld_dat(ld_dat), .ld_valid(ld_valid), .ld_ready(ld_ready)
  );

  always #5 clk = ~clk;

  // m2: 70 ns period (7 clk), edges never coincide with clk edges.
  bit m2_en = 1'b1;
  initial begin
    #3;
    forever begin
      #35;
      m2 = m2_en ? ~m2 : 1'b0;
    end
  end

  // sv_ready: tied high, or flipped every 3 cycles.
  bit rdy_toggle = 1'b0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) begin
        ph++;
        if (ph == 3) begin ph = 0; sv_ready = ~sv_ready; end
      end else begin
        sv_ready = 1'b1;
      end
    end
  end

  // Mapper model: registers written on the m2 fall while ss_we is high.
  logic [7:0] mem [0:15];
  logic [7:0] map_idx = 8'h00;
  logic       mem_load = 1'b0;
  int         wr_cnt = 0;
  assign ss_rdat = (ss_addr == 8'(IDX_ADDR)) ? map_idx :
                   (ss_addr < 8'(REG_CNT)) ? mem[ss_addr[3:0]] : 8'h00;

  always @(negedge m2 or posedge mem_load) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(i) ^ 8'h5A;
    end else if (ss_act && ss_we) begin
      if (ss_addr < 8'(REG_CNT)) mem[ss_addr[3:0]] = ss_wdat;
      wr_cnt++;
    end
  end

  // Passive monitor sampled on the falling clk edge.
  int         done_cnt = 0, we_cyc = 0, we_run = 0, last_run = 0;
  int         w0 = 0, win_bad = 0, stall_bad = 0;
  bit         prev_we = 1'b0, stalled = 1'b0;
  logic [7:0] hold_dat = 8'h00, hold_addr = 8'h00;
  logic [7:0] cap [$];
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ss_we) begin
      we_cyc++;
      if (!prev_we) w0 = wr_cnt;
      we_run++;
    end else if (prev_we) begin
      last_run = we_run;
      we_run   = 0;
      if (wr_cnt - w0 != 1) win_bad++;
    end
    prev_we = ss_we;
    if (sv_valid) begin
      if (stalled && (sv_dat !== hold_dat || ss_addr !== hold_addr)) stall_bad++;
      if (sv_ready) cap.push_back(sv_dat);
      stalled   = !sv_ready;
      hold_dat  = sv_dat;
      hold_addr = ss_addr;
    end else begin
      stalled = 1'b0;
    end
  end

  logic [7:0] ld_bytes [0:12];

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start(input logic d);
    @(posedge clk); #1;
    dir = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present ld_bytes in order; stops early once the sequencer goes idle.
  task automatic feed();
    bit got;
    for (int i = 0; i < 13; i++) begin
      ld_dat = ld_bytes[i]; ld_valid = 1'b1; got = 1'b0;
      for (int c = 0; c < 3 * TMO; c++) begin
        @(negedge clk);
        if (ld_ready) begin got = 1'b1; break; end
        if (!busy) break;
      end
      if (!got) break;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic align_m2();
    @(negedge m2);
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({busy, done, err, ss_act, ss_we, sv_valid, ld_ready} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, done, err, ss_act, ss_we, sv_valid, ld_ready});
    end
    tests++;
    if ({ss_addr, ss_wdat, sv_dat} !== 24'h0) begin
      fails++; $display("FAIL reset_data: got %h required 000000", {ss_addr, ss_wdat, sv_dat});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, ss_act, done} !== 3'b0) begin
      fails++; $display("FAIL reset_release_idle: got %b required 000", {busy, ss_act, done});
    end
  endtask

  task automatic test_save(input bit toggle);
    int base, d0, we0, sb0;
    bit ok;
    logic [7:0] exp;
    rdy_toggle = toggle;
    map_idx = 8'hC3;
    mem_load = 1'b1; #1; mem_load = 1'b0;
    base = cap.size(); d0 = done_cnt; we0 = we_cyc; sb0 = stall_bad;
    pulse_start(1'b0);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL save_busy: got %b required 1", busy); end
    wait_idle(2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL save_finish: busy still %b after budget, required 0", busy); end
    tests++;
    if (cap.size() - base != REG_CNT + 1) begin
      fails++; $display("FAIL save_count: got %0d bytes required %0d", cap.size() - base, REG_CNT + 1);
    end
    for (int i = 0; i <= REG_CNT; i++) begin
      exp = (i < REG_CNT) ? (8'(i) ^ 8'h5A) : 8'hC3;
      if (base + i < cap.size()) begin
        tests++;
        if (cap[base + i] !== exp) begin
          fails++; $display("FAIL save_byte%0d: got %h required %h", i, cap[base + i], exp);
        end
      end
    end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL save_done: got %0d pulses required 1", done_cnt - d0); end
    tests++;
    if (we_cyc - we0 != 0) begin fails++; $display("FAIL save_no_we: got %0d we cycles required 0", we_cyc - we0); end
    if (toggle) begin
      tests++;
      if (stall_bad - sb0 != 0) begin fails++; $display("FAIL save_stall_hold: got %0d changes required 0", stall_bad - sb0); end
    end
    rdy_toggle = 1'b0;
  endtask

  task automatic test_restore(input logic [7:0] base_val, input logic [7:0] idx_byte, input logic exp_err);
    int wr0, d0, wb0;
    bit ok;
    map_idx = 8'd32;
    for (int i = 0; i < REG_CNT; i++) ld_bytes[i] = base_val + 8'(i);
    ld_bytes[12] = idx_byte;
    wr0 = wr_cnt; d0 = done_cnt; wb0 = win_bad;
    align_m2();
    pulse_start(1'b1);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL restore_err_cleared: got %b required 0", err); end
    feed();
    wait_idle(2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL restore_finish: busy still %b after budget, required 0", busy); end
    tests++;
    if (wr_cnt - wr0 != REG_CNT) begin fails++; $display("FAIL restore_writes: got %0d required %0d", wr_cnt - wr0, REG_CNT); end
    for (int i = 0; i < REG_CNT; i++) begin
      tests++;
      if (mem[i] !== base_val + 8'(i)) begin
        fails++; $display("FAIL restore_reg%0d: got %h required %h", i, mem[i], base_val + 8'(i));
      end
    end
    tests++;
    if (win_bad - wb0 != 0) begin fails++; $display("FAIL restore_m2_window: got %0d bad windows required 0", win_bad - wb0); end
    tests++;
    if (err !== exp_err) begin fails++; $display("FAIL restore_err: got %b required %b", err, exp_err); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL restore_done: got %0d pulses required 1", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int wr0, d0;
    bit ok;
    map_idx = 8'd32;
    for (int i = 0; i < REG_CNT; i++) ld_bytes[i] = 8'h60 + 8'(i);
    ld_bytes[12] = 8'd32;
    wr0 = wr_cnt; d0 = done_cnt;
    align_m2();
    pulse_start(1'b1);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL tmo_err_cleared: got %b required 0", err); end
    fork
      feed();
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (wr_cnt - wr0 >= 4) begin m2_en = 1'b0; break; end
        end
      end
    join
    wait_idle(3 * TMO, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tmo_finish: busy still %b after budget, required 0", busy); end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b required 1", err); end
    tests++;
    if (ss_we !== 1'b0) begin fails++; $display("FAIL tmo_we: got %b required 0", ss_we); end
    tests++;
    if (last_run != TMO) begin fails++; $display("FAIL tmo_length: got %0d cycles required %0d", last_run, TMO); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL tmo_done: got %0d pulses required 1", done_cnt - d0); end
    m2_en = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (wr_cnt - wr0 != 4) begin fails++; $display("FAIL tmo_writes: got %0d required 4", wr_cnt - wr0); end
  endtask

  task automatic test_abort();
    int d0;
    // abort and start together in IDLE: start dropped, err untouched.
    @(posedge clk); #1;
    dir = 1'b0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, ss_act} !== 2'b00) begin fails++; $display("FAIL abort_start_same: got %b required 00", {busy, ss_act}); end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL abort_err_kept: got %b required 1", err); end
    // abort mid-save: straight to IDLE, no done pulse.
    d0 = done_cnt;
    pulse_start(1'b0);
    repeat (4) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if ({busy, ss_act, ss_we, sv_valid, ld_ready} !== 5'b0) begin
      fails++; $display("FAIL abort_outputs: got %b required 00000", {busy, ss_act, ss_we, sv_valid, ld_ready});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_restore();
    int wr0;
    map_idx = 8'd32;
    for (int i = 0; i < REG_CNT; i++) ld_bytes[i] = 8'h30 + 8'(i);
    ld_bytes[12] = 8'd32;
    wr0 = wr_cnt;
    align_m2();
    pulse_start(1'b1);
    fork
      feed();
      begin
        for (int c = 0; c < 500; c++) begin
          @(negedge clk);
          if (wr_cnt - wr0 >= 1) break;
        end
        // Second write: m2 rises, sync catches it, FSM is in LD_FALL.
        @(posedge m2);
        repeat (3) @(posedge clk); #1;
        tests++;
        if (ss_we !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_we: got %b required 1", ss_we); end
        rst_n = 1'b0; #1;
        tests++;
        if ({busy, done, ss_act, ss_we, sv_valid, ld_ready, ss_addr, ss_wdat} !== 22'h0) begin
          fails++; $display("FAIL rst_mid_outputs: got %h required 0", {busy, done, ss_act, ss_we, sv_valid, ld_ready, ss_addr, ss_wdat});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, ss_act} !== 2'b00) begin fails++; $display("FAIL rst_mid_idle: got %b required 00", {busy, ss_act}); end
    tests++;
    if (wr_cnt - wr0 != 1) begin fails++; $display("FAIL rst_mid_writes: got %0d required 1", wr_cnt - wr0); end
  endtask

  initial begin
    test_reset();
    test_save(1'b0);
    test_save(1'b1);
    test_restore(8'h10, 8'd32, 1'b0);
    test_restore(8'h10, 8'd33, 1'b1);
    test_timeout();
    test_abort();
    test_reset_mid_restore();
    test_restore(8'h40, 8'd32, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
